// File: rtl/game_timer_pkg.sv
// Shared definitions for the game countdown timer and the display driver.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BCD_W        = 4;
  localparam int SEC_TENS_MAX = 5;
  localparam int BCD_MAX      = 9;
  localparam int DIGIT_COUNT  = 4;

  // Digit positions inside the 16-bit MM:SS word; LSB of a digit is idx*BCD_W.
  localparam int SEC_ONES_IDX = 0;
  localparam int SEC_TENS_IDX = 1;
  localparam int MIN_ONES_IDX = 2;
  localparam int MIN_TENS_IDX = 3;

  // Largest legal value of a digit; also the value it wraps to on a borrow.
  function automatic logic [BCD_W-1:0] digit_limit(input int idx, input int max_tens);
    int lim;
    lim = BCD_MAX;
    if (idx == SEC_TENS_IDX) lim = SEC_TENS_MAX;
    if (idx == MIN_TENS_IDX) lim = (max_tens > BCD_MAX) ? BCD_MAX : max_tens;
    return BCD_W'(lim);
  endfunction

  // Saturate a loaded digit to its limit.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d,
                                                   input logic [BCD_W-1:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/game_timer_digit.sv
// One BCD down-counting digit with parallel load and wrap-on-borrow.
module bcd_down_digit
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec_en,
  input  logic [BCD_W-1:0] wrap_val,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  logic [BCD_W-1:0] digit_reg;

  // Digit register: load beats decrement; zero wraps to the digit's limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_reg <= '0;
    end else if (load) begin
      digit_reg <= load_val;
    end else if (dec_en) begin
      digit_reg <= (digit_reg == '0) ? wrap_val : digit_reg - BCD_W'(1);
    end
  end

  assign digit      = digit_reg;
  assign borrow_out = dec_en & (digit_reg == '0);

endmodule

// File: rtl/game_timer.sv
// MM:SS BCD countdown driven by the slow divider square wave.
module game_timer
  import game_pkg::*;
#(
  parameter int MAX_TENS_MIN = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] time_out,
  output logic        running,
  output logic        expired,
  output logic        done
);

  logic                 tick_prev_reg;
  logic                 sec_pulse;
  state_t               state_reg;
  logic                 running_reg;
  logic                 expired_reg;
  logic                 done_reg;
  logic [DIGIT_COUNT:0] borrow;
  logic                 count_is_one;
  logic                 count_is_zero;
  logic                 underflow;

  // Edge detector; resets high so a divider already high at release is not an edge.
  always_ff @(posedge clk) begin
    if (reset) tick_prev_reg <= 1'b1;
    else       tick_prev_reg <= tick_in;
  end

  assign sec_pulse = tick_in & ~tick_prev_reg;

  // The borrow chain starts with the one-second decrement request.
  assign borrow[0] = (state_reg == ST_RUN) & sec_pulse & ~load;

  generate
    for (genvar gi = 0; gi < DIGIT_COUNT; gi++) begin : g_digit
      localparam logic [BCD_W-1:0] LIMIT = digit_limit(gi, MAX_TENS_MIN);
      logic [BCD_W-1:0] load_clamped;

      assign load_clamped = clamp_digit(load_value[gi*BCD_W +: BCD_W], LIMIT);

      bcd_down_digit u_digit (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_val   (load_clamped),
        .dec_en     (borrow[gi]),
        .wrap_val   (LIMIT),
        .digit      (time_out[gi*BCD_W +: BCD_W]),
        .borrow_out (borrow[gi+1])
      );
    end
  endgenerate

  assign count_is_one  = (time_out == 16'h0001);
  assign count_is_zero = (time_out == 16'h0000);
  // Only reachable if RUN were ever entered at 00:00; treated as expiry.
  assign underflow     = borrow[DIGIT_COUNT];

  // Control FSM with registered status outputs; load > start > pause.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      running_reg <= 1'b0;
      expired_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      expired_reg <= 1'b0;
      if (load) begin
        state_reg   <= ST_IDLE;
        running_reg <= 1'b0;
        done_reg    <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              if (count_is_zero) begin
                state_reg   <= ST_DONE;
                done_reg    <= 1'b1;
                expired_reg <= 1'b1;
              end else begin
                state_reg   <= ST_RUN;
                running_reg <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if ((sec_pulse && count_is_one) || underflow) begin
              state_reg   <= ST_DONE;
              running_reg <= 1'b0;
              done_reg    <= 1'b1;
              expired_reg <= 1'b1;
            end else if (pause) begin
              state_reg   <= ST_PAUSE;
              running_reg <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (start) begin
              state_reg   <= ST_RUN;
              running_reg <= 1'b1;
            end
          end
          default: begin
            state_reg <= ST_DONE;
          end
        endcase
      end
    end
  end

  assign running = running_reg;
  assign expired = expired_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with a seconds-based reference model.
module tb_game_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_in;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        pause;
  logic [15:0] time_out;
  logic        running;
  logic        expired;
  logic        done;

  int total = 0;
  int bad   = 0;
  int exp_seen = 0;

  always #5 clk = ~clk;

  game_timer #(.MAX_TENS_MIN(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_in    (tick_in),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .time_out   (time_out),
    .running    (running),
    .expired    (expired),
    .done       (done)
  );

  // Reference model: remaining time as a plain number of seconds plus mode flags.
  int m_secs  = 0;
  bit m_run   = 1'b0;
  bit m_pause = 1'b0;
  bit m_done  = 1'b0;
  bit m_exp   = 1'b0;
  bit m_prev  = 1'b1;
  bit chk_en  = 1'b0;
  wire model_pulse = tick_in & ~m_prev;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int clamp_load(input logic [15:0] v);
    int so, st, mo, mt;
    so = min_int(int'(v[3:0]), 9);
    st = min_int(int'(v[7:4]), 5);
    mo = min_int(int'(v[11:8]), 9);
    mt = min_int(int'(v[15:12]), 5);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Model update on each clock edge from the sampled inputs.
  always @(posedge clk) begin
    m_prev <= tick_in;
    m_exp  <= 1'b0;
    if (reset) begin
      chk_en  <= 1'b1;
      m_secs  <= 0;
      m_run   <= 1'b0;
      m_pause <= 1'b0;
      m_done  <= 1'b0;
    end else if (load) begin
      m_secs  <= clamp_load(load_value);
      m_run   <= 1'b0;
      m_pause <= 1'b0;
      m_done  <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b1;
    end else if (m_run) begin
      if (model_pulse) m_secs <= m_secs - 1;
      if (model_pulse && m_secs == 1) begin
        m_run  <= 1'b0;
        m_done <= 1'b1;
        m_exp  <= 1'b1;
      end else if (pause) begin
        m_run   <= 1'b0;
        m_pause <= 1'b1;
      end
    end else if (m_pause) begin
      if (start) begin
        m_pause <= 1'b0;
        m_run   <= 1'b1;
      end
    end else if (start) begin
      if (m_secs == 0) begin
        m_done <= 1'b1;
        m_exp  <= 1'b1;
      end else begin
        m_run <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("time_out", time_out, to_bcd(m_secs));
      check("running", 16'(running), 16'(m_run));
      check("expired", 16'(expired), 16'(m_exp));
      check("done", 16'(done), 16'(m_done));
    end
    if (expired === 1'b1) exp_seen++;
  end

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    check(name, act, exp);
    $display("txn %-16s value=%h want=%h", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load       = 1'b1;
    load_value = v;
    cycles(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic tick_edges(input int n);
    repeat (n) begin
      tick_in = 1'b1;
      cycles(10);
      tick_in = 1'b0;
      cycles(10);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_tbl [4];
    exp_tbl[0] = 16'h0102;
    exp_tbl[1] = 16'h0101;
    exp_tbl[2] = 16'h0100;
    exp_tbl[3] = 16'h0059;

    reset = 1'b1; tick_in = 1'b1; load = 1'b0; load_value = 16'h0000;
    start = 1'b0; pause = 1'b0;
    cycles(3);
    reset = 1'b0;
    cycles(5);
    lit("reset_time", time_out, 16'h0000);
    lit("reset_done", 16'(done), 16'h0000);
    tick_in = 1'b0;
    cycles(2);

    // Basic countdown with borrow
    do_load(16'h0103);
    do_start();
    lit("run_after_start", 16'(running), 16'h0001);
    for (int i = 0; i < 4; i++) begin
      tick_in = 1'b1;
      cycles(10);
      lit("countdown", time_out, exp_tbl[i]);
      tick_in = 1'b0;
      cycles(10);
    end

    // Expiry
    do_load(16'h0002);
    exp_seen = 0;
    do_start();
    tick_edges(2);
    lit("expiry_time", time_out, 16'h0000);
    lit("expiry_done", 16'(done), 16'h0001);
    lit("expiry_running", 16'(running), 16'h0000);
    lit("expiry_pulses", 16'(exp_seen), 16'h0001);
    tick_edges(2);
    do_start();
    cycles(2);
    lit("done_hold_time", time_out, 16'h0000);
    lit("done_hold_done", 16'(done), 16'h0001);
    lit("done_hold_pulses", 16'(exp_seen), 16'h0001);

    // Pause / resume
    do_load(16'h0130);
    do_start();
    pause = 1'b1;
    cycles(1);
    pause = 1'b0;
    tick_edges(3);
    lit("paused_time", time_out, 16'h0130);
    lit("paused_running", 16'(running), 16'h0000);
    do_start();
    tick_edges(1);
    lit("resumed_time", time_out, 16'h0129);

    // Pause together with a second edge: decrement still happens
    tick_in = 1'b1;
    pause   = 1'b1;
    cycles(1);
    pause = 1'b0;
    cycles(9);
    tick_in = 1'b0;
    cycles(10);
    lit("pause_edge_time", time_out, 16'h0128);
    lit("pause_edge_run", 16'(running), 16'h0000);
    tick_edges(1);
    lit("pause_edge_hold", time_out, 16'h0128);

    // Load clamp and zero start
    do_load(16'hFA7C);
    cycles(1);
    lit("clamp", time_out, 16'h5959);
    do_load(16'h0000);
    exp_seen = 0;
    do_start();
    cycles(2);
    lit("zero_start_done", 16'(done), 16'h0001);
    lit("zero_start_pulse", 16'(exp_seen), 16'h0001);

    // Load beats start and a simultaneous second edge
    do_load(16'h0310);
    do_start();
    cycles(3);
    lit("prio_running", 16'(running), 16'h0001);
    tick_in    = 1'b1;
    load       = 1'b1;
    load_value = 16'h0245;
    start      = 1'b1;
    cycles(1);
    load  = 1'b0;
    start = 1'b0;
    cycles(9);
    tick_in = 1'b0;
    cycles(5);
    lit("prio_time", time_out, 16'h0245);
    lit("prio_running", 16'(running), 16'h0000);

    // Reset mid-count with the divider held high across release
    do_start();
    tick_edges(1);
    lit("pre_reset_time", time_out, 16'h0244);
    tick_in = 1'b1;
    reset   = 1'b1;
    cycles(1);
    reset = 1'b0;
    lit("mid_reset_time", time_out, 16'h0000);
    lit("mid_reset_run", 16'(running), 16'h0000);
    do_load(16'h0010);
    do_start();
    cycles(8);
    lit("no_false_edge", time_out, 16'h0010);
    tick_in = 1'b0;
    cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
